// File: rtl/vdb_vga_timing_gen.sv
// VGA timing generator: parameterised hsync/vsync/de timing, fixed-latency pixel
// requests to an upstream source, and built-in test patterns.
module vdb_vga_timing_gen #(
  parameter int HOR_ACT   = 640,
  parameter int HOR_FP    = 16,
  parameter int HOR_SYNC  = 96,
  parameter int HOR_BP    = 48,
  parameter int VERT_ACT  = 480,
  parameter int VERT_FP   = 11,
  parameter int VERT_SYNC = 2,
  parameter int VERT_BP   = 31,
  parameter int SYNC_POL  = 0
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        req,
  output logic [10:0] req_x,
  output logic [9:0]  req_y,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        busy
);

  localparam int HTOTAL = HOR_ACT + HOR_FP + HOR_SYNC + HOR_BP;
  localparam int VTOTAL = VERT_ACT + VERT_FP + VERT_SYNC + VERT_BP;
  localparam int BAR_W  = (HOR_ACT >= 8) ? HOR_ACT / 8 : 1;

  localparam logic [10:0] H_LAST   = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(VTOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(HOR_ACT);
  localparam logic [10:0] V_ACT    = 11'(VERT_ACT);
  localparam logic [10:0] HS_FIRST = 11'(HOR_ACT + HOR_FP);
  localparam logic [10:0] HS_LAST  = 11'(HOR_ACT + HOR_FP + HOR_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(VERT_ACT + VERT_FP);
  localparam logic [10:0] VS_LAST  = 11'(VERT_ACT + VERT_FP + VERT_SYNC - 1);
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
  localparam logic        SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [10:0] bar_pix_q, bar_pix_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;

  logic        frame_end, act0, running;
  logic [10:0] h_adv, v_adv;

  // Sequencer: state, counters and the per-frame pattern latch.
  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    mode_d    = mode_q;
    frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    h_adv     = (h_cnt_q == H_LAST) ? 11'd0 : h_cnt_q + 11'd1;
    if (h_cnt_q == H_LAST) begin
      v_adv = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end else begin
      v_adv = v_cnt_q;
    end
    case (state_q)
      IDLE: begin
        h_cnt_d = 11'd0;
        v_cnt_d = 11'd0;
        if (enable) begin
          state_d = RUN;
          mode_d  = pattern_sel;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        h_cnt_d = h_adv;
        v_cnt_d = v_adv;
        state_d = enable ? RUN : STOP;
        if (frame_end) begin
          mode_d = pattern_sel;
        end else begin
          mode_d = mode_q;
        end
      end
      STOP: begin
        if (enable) begin
          state_d = RUN;
          h_cnt_d = h_adv;
          v_cnt_d = v_adv;
          if (frame_end) begin
            mode_d = pattern_sel;
          end else begin
            mode_d = mode_q;
          end
        end else if (frame_end) begin
          state_d = IDLE;
          h_cnt_d = 11'd0;
          v_cnt_d = 11'd0;
        end else begin
          h_cnt_d = h_adv;
          v_cnt_d = v_adv;
        end
      end
      default: begin
        state_d = IDLE;
        h_cnt_d = 11'd0;
        v_cnt_d = 11'd0;
      end
    endcase
  end

  // Stage 0 request port and stage-1 next values.
  always_comb begin
    running   = (state_q != IDLE);
    act0      = running && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    req       = act0 && (mode_q == 2'd0);
    req_x     = act0 ? h_cnt_q : 11'd0;
    req_y     = act0 ? v_cnt_q[9:0] : 10'd0;
    bar_pix_d = 11'd0;
    bar_idx_d = 3'd0;
    if (act0) begin
      if (bar_pix_q == BAR_LAST) begin
        bar_pix_d = 11'd0;
        bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + 11'd1;
        bar_idx_d = bar_idx_q;
      end
    end else begin
      bar_pix_d = 11'd0;
      bar_idx_d = 3'd0;
    end
    de_d = act0;
    fs_d = act0 && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    r_d  = 8'h00;
    g_d  = 8'h00;
    b_d  = 8'h00;
    if (act0) begin
      case (mode_q)
        2'd0: begin
          r_d = pix_r;
          g_d = pix_g;
          b_d = pix_b;
        end
        2'd1: begin
          // Bar order white..black maps to idx bits: R=~idx[1], G=~idx[2], B=~idx[0].
          r_d = {8{~bar_idx_q[1]}};
          g_d = {8{~bar_idx_q[2]}};
          b_d = {8{~bar_idx_q[0]}};
        end
        2'd2: begin
          r_d = ((h_cnt_q[3:0] == 4'd0) || (v_cnt_q[3:0] == 4'd0)) ? 8'hFF : 8'h00;
          g_d = r_d;
          b_d = r_d;
        end
        default: begin
          r_d = 8'h00;
          g_d = 8'h00;
          b_d = 8'h00;
        end
      endcase
    end else begin
      r_d = 8'h00;
      g_d = 8'h00;
      b_d = 8'h00;
    end
    if (running && (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) begin
      hsync_d = SYNC_ON;
    end else begin
      hsync_d = ~SYNC_ON;
    end
    if (running && (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) begin
      vsync_d = SYNC_ON;
    end else begin
      vsync_d = ~SYNC_ON;
    end
  end

  // State, counter and stage-1 registers with synchronous reset.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      h_cnt_q   <= 11'd0;
      v_cnt_q   <= 11'd0;
      mode_q    <= 2'd0;
      bar_pix_q <= 11'd0;
      bar_idx_q <= 3'd0;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      mode_q    <= mode_d;
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vdb_vga_timing_gen.sv
// Directed bench for vdb_vga_timing_gen on a 14x8 total / 8x4 active raster,
// plus a 16-pixel-wide instance for colour-bar width checks.
module tb_vdb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
  } out_t;

  localparam out_t IDLE_OUT = {8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        req, hsync, vsync, de, frame_start, busy;
  logic [10:0] req_x;
  logic [9:0]  req_y;
  logic [7:0]  r, g, b, pix_r, pix_g, pix_b;
  logic        req2, hsync2, vsync2, de2, frame_start2, busy2;
  logic [10:0] req_x2;
  logic [9:0]  req_y2;
  logic [7:0]  r2, g2, b2;

  int vectors = 0;
  int miscompares = 0;

  out_t        got1;
  logic [22:0] ctl1;
  logic [24:0] got2;

  // Ramp source: combinational from the request coordinates.
  assign pix_r = req_x[7:0];
  assign pix_g = req_y[7:0];
  assign pix_b = {req_x[3:0], req_y[3:0]};
  assign got1  = {r, g, b, de, hsync, vsync, frame_start};
  assign ctl1  = {busy, req, req_x, req_y};
  assign got2  = {r2, g2, b2, de2};

  always #5 pixel_clk = ~pixel_clk;

  vdb_vga_timing_gen #(
    .HOR_ACT(8), .HOR_FP(2), .HOR_SYNC(3), .HOR_BP(1),
    .VERT_ACT(4), .VERT_FP(1), .VERT_SYNC(1), .VERT_BP(2), .SYNC_POL(0)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .req(req), .req_x(req_x), .req_y(req_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .busy(busy)
  );

  vdb_vga_timing_gen #(
    .HOR_ACT(16), .HOR_FP(2), .HOR_SYNC(3), .HOR_BP(1),
    .VERT_ACT(4), .VERT_FP(1), .VERT_SYNC(1), .VERT_BP(2), .SYNC_POL(0)
  ) dut2 (
    .pixel_clk(pixel_clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .req(req2), .req_x(req_x2), .req_y(req_y2),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .r(r2), .g(g2), .b(b2), .hsync(hsync2), .vsync(vsync2), .de(de2),
    .frame_start(frame_start2), .busy(busy2)
  );

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected stage-1 outputs for raster position pos (0 = first active pixel).
  function automatic out_t exp_out(input int pos, input int mode);
    int h, v;
    out_t o;
    h = pos % HT;
    v = (pos / HT) % VT;
    o = '0;
    o.de = (h < 8) && (v < 4);
    o.hs = !((h >= 10) && (h <= 12));
    o.vs = (v != 5);
    o.fs = (h == 0) && (v == 0);
    if (o.de) begin
      case (mode)
        0: begin
          o.r = 8'(h);
          o.g = 8'(v);
          o.b = {4'(h), 4'(v)};
        end
        1: {o.r, o.g, o.b} = bar_rgb(h);
        2: {o.r, o.g, o.b} = ((h % 16 == 0) || (v % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
        default: {o.r, o.g, o.b} = 24'h000000;
      endcase
    end
    return o;
  endfunction

  // Expected {busy, req, req_x, req_y} with the counters at position q.
  function automatic logic [22:0] exp_ctl(input logic bz, input int q, input int mode);
    int h, v;
    logic act;
    h = q % HT;
    v = (q / HT) % VT;
    act = (h < 8) && (v < 4);
    return {bz, act && (mode == 0), act ? 11'(h) : 11'd0, act ? 10'(v) : 10'd0};
  endfunction

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // Reset, then raise enable; returns just after the IDLE->RUN edge.
  task automatic start_run(input logic [1:0] sel);
    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = sel;
    tick();
    rst = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    vectors++;
    if (got1 !== IDLE_OUT) begin
      miscompares++;
      $display("FAIL reset_out got=%h exp=%h", got1, IDLE_OUT);
    end
    vectors++;
    if (ctl1 !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_ctl got=%h exp=%h", ctl1, 23'd0);
    end
  endtask

  task automatic test_ramp();
    start_run(2'd0);
    vectors++;
    if (ctl1 !== exp_ctl(1'b1, 0, 0)) begin
      miscompares++;
      $display("FAIL ramp_first_req got=%h exp=%h", ctl1, exp_ctl(1'b1, 0, 0));
    end
    for (int n = 0; n < 2 * FT; n++) begin
      tick();
      vectors++;
      if (got1 !== exp_out(n, 0)) begin
        miscompares++;
        $display("FAIL ramp_out n=%0d got=%h exp=%h", n, got1, exp_out(n, 0));
      end
      vectors++;
      if (ctl1 !== exp_ctl(1'b1, n + 1, 0)) begin
        miscompares++;
        $display("FAIL ramp_ctl n=%0d got=%h exp=%h", n, ctl1, exp_ctl(1'b1, n + 1, 0));
      end
    end
  endtask

  task automatic test_colour_bars();
    logic [24:0] e2;
    start_run(2'd1);
    for (int n = 0; n < 22; n++) begin
      tick();
      e2 = (n < 16) ? {bar_rgb(n / 2), 1'b1} : 25'd0;
      vectors++;
      if (got2 !== e2) begin
        miscompares++;
        $display("FAIL bars16 n=%0d got=%h exp=%h", n, got2, e2);
      end
      if (n < HT) begin
        vectors++;
        if (got1 !== exp_out(n, 1)) begin
          miscompares++;
          $display("FAIL bars8 n=%0d got=%h exp=%h", n, got1, exp_out(n, 1));
        end
      end
    end
  endtask

  task automatic test_stop();
    logic [22:0] ec;
    start_run(2'd0);
    for (int n = 0; n < FT + 4; n++) begin
      tick();
      if (n == 27) enable = 1'b0;
      ec = (n <= FT - 2) ? exp_ctl(1'b1, n + 1, 0) : 23'd0;
      vectors++;
      if (ctl1 !== ec) begin
        miscompares++;
        $display("FAIL stop_ctl n=%0d got=%h exp=%h", n, ctl1, ec);
      end
      vectors++;
      if (n < FT) begin
        if (got1 !== exp_out(n, 0)) begin
          miscompares++;
          $display("FAIL stop_out n=%0d got=%h exp=%h", n, got1, exp_out(n, 0));
        end
      end else if (got1 !== IDLE_OUT) begin
        miscompares++;
        $display("FAIL stop_drained n=%0d got=%h exp=%h", n, got1, IDLE_OUT);
      end
    end
  endtask

  task automatic test_stop_restart();
    start_run(2'd0);
    for (int n = 0; n < FT + 20; n++) begin
      tick();
      if (n == 27) enable = 1'b0;
      if (n == 47) enable = 1'b1;
      vectors++;
      if (got1 !== exp_out(n, 0)) begin
        miscompares++;
        $display("FAIL restart_out n=%0d got=%h exp=%h", n, got1, exp_out(n, 0));
      end
      vectors++;
      if (ctl1 !== exp_ctl(1'b1, n + 1, 0)) begin
        miscompares++;
        $display("FAIL restart_ctl n=%0d got=%h exp=%h", n, ctl1, exp_ctl(1'b1, n + 1, 0));
      end
    end
  endtask

  task automatic test_mode_switch();
    int mo, mq;
    start_run(2'd0);
    for (int n = 0; n < FT + 30; n++) begin
      tick();
      if (n == 29) pattern_sel = 2'd2;
      mo = (n < FT) ? 0 : 2;
      mq = (n + 1 < FT) ? 0 : 2;
      vectors++;
      if (got1 !== exp_out(n, mo)) begin
        miscompares++;
        $display("FAIL switch_out n=%0d got=%h exp=%h", n, got1, exp_out(n, mo));
      end
      vectors++;
      if (ctl1 !== exp_ctl(1'b1, n + 1, mq)) begin
        miscompares++;
        $display("FAIL switch_ctl n=%0d got=%h exp=%h", n, ctl1, exp_ctl(1'b1, n + 1, mq));
      end
    end
  endtask

  task automatic test_sync_reset();
    start_run(2'd0);
    for (int n = 0; n < 46; n++) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (got1 !== IDLE_OUT) begin
      miscompares++;
      $display("FAIL midrst_out got=%h exp=%h", got1, IDLE_OUT);
    end
    vectors++;
    if (ctl1 !== 23'd0) begin
      miscompares++;
      $display("FAIL midrst_ctl got=%h exp=%h", ctl1, 23'd0);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (ctl1 !== exp_ctl(1'b1, 0, 0)) begin
      miscompares++;
      $display("FAIL midrst_restart_req got=%h exp=%h", ctl1, exp_ctl(1'b1, 0, 0));
    end
    for (int n = 0; n < 20; n++) begin
      tick();
      vectors++;
      if (got1 !== exp_out(n, 0)) begin
        miscompares++;
        $display("FAIL midrst_out2 n=%0d got=%h exp=%h", n, got1, exp_out(n, 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_colour_bars();
    test_stop();
    test_stop_restart();
    test_mode_switch();
    test_sync_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
